// File: rtl/register_bank_pkg.sv
// register_bank_pkg: definitions shared by the register bank and its dump engine.
// Provides the default widths, the dump FSM state encoding and the index of
// the hardwired zero register.
package register_bank_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  // Index of the register that reads as zero when ZERO_REG is enabled.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } dump_state_e;

endpackage

// File: rtl/register_dump_fsm.sv
// register_dump_fsm: debug dump engine for the register bank.
// On a dump_start pulse in IDLE it walks every register index, one per cycle,
// and presents index/value on dump_addr/dump_data with dump_valid high.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   dump_start     pulse that starts a scan (ignored while scanning)
//   rd_addr        index the bank should read for the current beat
//   rd_data        registered (non-bypassed) value at rd_addr
//   dump_busy      scan in progress
//   dump_valid     dump_addr/dump_data are valid this cycle
//   dump_addr      index of the register being presented
//   dump_data      value of the register being presented
module register_dump_fsm
  import register_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);

  localparam int NREG = 2 ** ADDR_W;
  // The counter is one bit wider than an address so the last index is never
  // confused with a wrap back to 0.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NREG - 1);
  localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  dump_state_e       state_r;
  dump_state_e       state_n;
  logic [ADDR_W:0]   index_r;
  logic [ADDR_W:0]   index_n;

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      index_r <= '0;
    end else begin
      state_r <= state_n;
      index_r <= index_n;
    end
  end

  // Next-state logic: start only from IDLE, stop after the last index.
  always_comb begin
    state_n = state_r;
    index_n = index_r;
    case (state_r)
      IDLE: begin
        if (dump_start) begin
          state_n = SCAN;
          index_n = '0;
        end else begin
          state_n = IDLE;
          index_n = '0;
        end
      end
      SCAN: begin
        if (index_r == LAST_IDX) begin
          state_n = IDLE;
          index_n = '0;
        end else begin
          state_n = SCAN;
          index_n = index_r + IDX_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        index_n = '0;
      end
    endcase
  end

  // Beat outputs are decoded from the state register; they hold 0 in IDLE.
  always_comb begin
    rd_addr = index_r[ADDR_W-1:0];
    if (state_r == SCAN) begin
      dump_busy  = 1'b1;
      dump_valid = 1'b1;
      dump_addr  = index_r[ADDR_W-1:0];
      dump_data  = rd_data;
    end else begin
      dump_busy  = 1'b0;
      dump_valid = 1'b0;
      dump_addr  = '0;
      dump_data  = '0;
    end
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: architectural register file with two combinational read
// ports, write-through bypass and a debug dump engine.
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   wr_en, wr_addr           write enable and destination register
//   write_data               writeback value
//   rd_addr_a, rd_addr_b     read port addresses
//   rd_data_a, rd_data_b     read port data (bypassed from a same-cycle write)
//   dump_start               pulse: stream all registers out
//   dump_busy, dump_valid    dump status
//   dump_addr, dump_data     dumped register index and value
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [ADDR_W-1:0] dump_rd_addr;
  logic [DATA_W-1:0] dump_rd_data;

  // Storage: clear on reset, drop writes aimed at the hardwired zero register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en && !(ZERO_REG && (wr_addr == ZERO_ADDR))) begin
      regs_r[wr_addr] <= write_data;
    end
  end

  // Read port A: the zero-register test comes first so the bypass never fires for it.
  always_comb begin
    if (ZERO_REG && (rd_addr_a == ZERO_ADDR)) begin
      rd_data_a = '0;
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = write_data;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
  end

  // Read port B: same structure as port A.
  always_comb begin
    if (ZERO_REG && (rd_addr_b == ZERO_ADDR)) begin
      rd_data_b = '0;
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = write_data;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end

  // Dump read: registered value only, no bypass.
  always_comb begin
    if (ZERO_REG && (dump_rd_addr == ZERO_ADDR)) begin
      dump_rd_data = '0;
    end else begin
      dump_rd_data = regs_r[dump_rd_addr];
    end
  end

  register_dump_fsm #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .rd_addr    (dump_rd_addr),
    .rd_data    (dump_rd_data),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: self-checking bench for register_bank.
// A shadow register model supplies expected values; they are pushed to a
// scoreboard queue when stimulus is applied and popped when outputs are sampled.
module tb_register_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] write_data;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          dump_start;
  logic          dump_busy;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;

  int vec_count = 0;
  int err_count = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] model_mem [NR];

  always #5 clk = ~clk;

  register_bank #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .ZERO_REG(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .write_data (write_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model_mem[i] = '0;
  endtask

  // One write cycle; the model mirrors the zero-register rule.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; write_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a != 5'd0) model_mem[a] = d;
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; write_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; dump_start = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    vec_count++;
    if ({dump_busy, dump_valid} !== 2'b00 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      err_count++;
      $display("FAIL reset_dump busy=%b valid=%b addr=%0d data=%h required all 0",
               dump_busy, dump_valid, dump_addr, dump_data);
    end
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      rd_addr_a = AW'(i); rd_addr_b = AW'(NR - 1 - i);
      exp_q.push_back(model_mem[i]);
      exp_q.push_back(model_mem[NR - 1 - i]);
      #1;
      e = exp_q.pop_front(); vec_count++;
      if (rd_data_a !== e) begin
        err_count++;
        $display("FAIL reset_rd_a addr=%0d got=%h required=%h", i, rd_data_a, e);
      end
      e = exp_q.pop_front(); vec_count++;
      if (rd_data_b !== e) begin
        err_count++;
        $display("FAIL reset_rd_b addr=%0d got=%h required=%h", NR - 1 - i, rd_data_b, e);
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    do_write(5'd5, 32'hDEADBEEF);
    rd_addr_a = 5'd5; rd_addr_b = 5'd6;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0000_0000);
    #1;
    e = exp_q.pop_front(); vec_count++;
    if (rd_data_a !== e) begin
      err_count++; $display("FAIL wr_rd_a got=%h required=%h", rd_data_a, e);
    end
    e = exp_q.pop_front(); vec_count++;
    if (rd_data_b !== e) begin
      err_count++; $display("FAIL wr_rd_b got=%h required=%h", rd_data_b, e);
    end
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(1, NR - 1));
      do_write(a, $urandom());
      rd_addr_a = a; rd_addr_b = a;
      exp_q.push_back(model_mem[a]);
      #1;
      e = exp_q.pop_front(); vec_count++;
      if (rd_data_a !== e || rd_data_b !== e) begin
        err_count++;
        $display("FAIL rand_rd addr=%0d a=%h b=%h required=%h", a, rd_data_a, rd_data_b, e);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] e;
    do_write(5'd7, 32'h0BAD_F00D);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; write_data = 32'h12345678;
    rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    exp_q.push_back(32'h12345678);
    #1;
    e = exp_q.pop_front(); vec_count++;
    if (rd_data_a !== e || rd_data_b !== e) begin
      err_count++;
      $display("FAIL bypass a=%h b=%h required=%h", rd_data_a, rd_data_b, e);
    end
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[7] = 32'h12345678;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; write_data = 32'hFFFFFFFF;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    exp_q.push_back(32'h0000_0000);
    #1;
    vec_count++;
    if (rd_data_a !== exp_q[0] || rd_data_b !== exp_q[0]) begin
      err_count++;
      $display("FAIL zero_bypass a=%h b=%h required=%h", rd_data_a, rd_data_b, exp_q[0]);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    vec_count++;
    if (rd_data_a !== exp_q[0]) begin
      err_count++;
      $display("FAIL zero_write got=%h required=%h", rd_data_a, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_dump();
    int beats = 0;
    logic [DW-1:0] e;
    logic [AW-1:0] ea;
    for (int i = 0; i < NR; i++) do_write(AW'(i), DW'(i * 4));
    @(negedge clk);
    dump_start = 1'b1;
    for (int i = 0; i < NR; i++) begin
      exp_addr_q.push_back(AW'(i));
      exp_q.push_back(model_mem[i]);
    end
    for (int cyc = 0; cyc < 40 && beats < NR; cyc++) begin
      @(negedge clk);
      dump_start = (beats == 5);
      #1;
      if (dump_valid === 1'b1) begin
        ea = exp_addr_q.pop_front();
        e = exp_q.pop_front();
        vec_count++;
        if (dump_addr !== ea || dump_data !== e || dump_busy !== 1'b1) begin
          err_count++;
          $display("FAIL dump_beat addr=%0d data=%h busy=%b required addr=%0d data=%h busy=1",
                   dump_addr, dump_data, dump_busy, ea, e);
        end
        beats++;
      end else if (beats > 0) begin
        vec_count++; err_count++;
        $display("FAIL dump_gap at beat=%0d valid=%b required 1", beats, dump_valid);
      end
    end
    vec_count++;
    if (beats != NR) begin
      err_count++;
      $display("FAIL dump_count got=%0d required=%0d", beats, NR);
    end
    dump_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      vec_count++;
      if ({dump_busy, dump_valid} !== 2'b00 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
        err_count++;
        $display("FAIL dump_end k=%0d busy=%b valid=%b addr=%0d data=%h required all 0",
                 k, dump_busy, dump_valid, dump_addr, dump_data);
      end
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 1'b0;
    logic [DW-1:0] e;
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      #1;
      if (dump_valid === 1'b1 && dump_addr === 5'd10) hit = 1'b1;
      else @(negedge clk);
    end
    vec_count++;
    if (!hit) begin
      err_count++;
      $display("FAIL mid_dump_beat10 not observed, required beat 10");
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    vec_count++;
    if ({dump_busy, dump_valid} !== 2'b00 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      err_count++;
      $display("FAIL mid_dump_reset busy=%b valid=%b addr=%0d data=%h required all 0",
               dump_busy, dump_valid, dump_addr, dump_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      exp_q.push_back(model_mem[i]);
      #1;
      e = exp_q.pop_front(); vec_count++;
      if (rd_data_a !== e || rd_data_b !== e) begin
        err_count++;
        $display("FAIL post_reset_rd addr=%0d a=%h b=%h required=%h", i, rd_data_a, rd_data_b, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_dump();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Architectural register file of the processor datapath.
- Receives the writeback value chosen by the writeback-select stage. Drives two combinational read ports to the ALU/branch logic.
- Contains a debug dump engine. On request it streams every register out, one per cycle, for bench checking and board-level inspection.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  commit write_data to register wr_addr this cycle.
- wr_addr  input  ADDR_W  destination register.
- write_data  input  DATA_W  writeback value from the writeback-select stage.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.
- dump_start  input  1  pulse: begin streaming all registers.
- dump_busy  output  1  dump in progress.
- dump_valid  output  1  dump_addr/dump_data valid this cycle.
- dump_addr  output  ADDR_W  index of dumped register.
- dump_data  output  DATA_W  value of dumped register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NREG registers clear to 0.
  - Dump FSM goes to IDLE.
  - dump_busy, dump_valid, dump_addr and dump_data are all 0.
  - rd_data_a/b read 0, since the registers are 0.
- Write:
  - When wr_en=1 at a rising clk, reg[wr_addr] takes write_data. Latency is 1 cycle.
  - When ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read:
  - Combinational: rd_data_x = reg[rd_addr_x].
  - When ZERO_REG=1 and rd_addr_x=0, the output is 0.
- Write-through bypass: if wr_en=1 and wr_addr==rd_addr_x (and the address is not the hardwired zero register), rd_data_x = write_data in the same cycle. This covers the writeback/decode overlap.
- Both read ports may address the same register; both return identical data.
- Dump FSM, states IDLE and SCAN:
  - IDLE -> SCAN on dump_start=1. The index counter loads 0 and dump_busy is 1 from the next cycle.
  - SCAN, each cycle:
    - dump_valid=1, dump_addr=index, dump_data=reg[index]. The value is the registered value, not bypassed.
    - index increments.
  - SCAN -> IDLE after index NREG-1 is presented. dump_busy and dump_valid fall the following cycle.
  - Exactly NREG valid beats per dump, with no gaps.
  - dump_start while in SCAN is ignored; there is no restart.
  - Writes during SCAN are permitted. A register written before its beat shows the new value; one written after its beat does not.
  - Index counter is ADDR_W+1 bits wide so termination is unambiguous, with no wrap to 0.
  - Reset mid-scan: immediate return to IDLE with all dump outputs 0. The register contents are also cleared.
- Outputs in IDLE: dump_addr and dump_data hold 0.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W defaults.
  - Dump FSM state encoding: IDLE=1'b0, SCAN=1'b1.
  - Register index constant REG_ZERO=0.
- One sub-module, register_dump_fsm:
  - Contains the state, index counter and dump_busy/dump_valid generation.
  - Takes a read-data input so it can produce dump_addr and dump_data.
  - The storage array and bypass stay in register_bank.

Test Plan:
- Reset, then read all addresses on both ports -> every rd_data = 0. Dump outputs = 0.
- wr_en=1, wr_addr=5, write_data=32'hDEADBEEF; next cycle rd_addr_a=5 -> rd_data_a=32'hDEADBEEF. rd_addr_b=6 -> 0.
- Same-cycle wr_en=1, wr_addr=7, write_data=32'h12345678 with rd_addr_a=rd_addr_b=7 -> both ports show 32'h12345678 in that cycle (bypass).
- ZERO_REG=1: write 32'hFFFFFFFF to address 0 -> rd_data_a for address 0 stays 0. The bypass does not fire.
- Preload reg[i]=i*4 for all i, then pulse dump_start -> 32 consecutive dump_valid beats with dump_addr=0..31 and dump_data=0,4,...,124. dump_busy drops one cycle after the last beat. A second dump_start mid-scan has no effect.
- Start a dump, deassert rst_n at beat 10 -> dump_busy, dump_valid and dump_data drop to 0 immediately (asynchronously). After release, all registers read 0.
